mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset; ports are listed below as: name, direction, width, meaning.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 rst  in  1  asynchronous active-high reset.
REQ-004 pc_i, ALU_i, forward_b_data_i  in  32 each  EX/MEM PC, ALU result (also the memory address), and store data.
REQ-005 RegDst_i  in  5; MemR_i, MemW_i, RegWEn_i  in  1 each; WBSel_i  in  2  EX/MEM control fields.
REQ-006 dmem_req_o  out  1; dmem_we_o  out  1; dmem_addr_o  out  32; dmem_wdata_o  out  32  data-memory request.
REQ-007 dmem_ack_i  in  1; dmem_rdata_i  in  32  data-memory completion and read data.
REQ-008 stall_o  out  1  combinational; when 1, upstream holds the EX/MEM inputs stable.
REQ-009 wb_data_o  out  32; RegDst_o  out  5; RegWEn_o  out  1  registered MEM/WB outputs.
REQ-010 bus_err_o  out  1  one-cycle pulse on access timeout (see Configuration).

Function
REQ-011 The FSM SHALL have two states, IDLE and BUSY.
REQ-012 An access is MemR_i|MemW_i; MemW_i takes precedence when both are set (write, read data discarded).
REQ-013 IDLE with an access: stall_o=1; at the next edge go to BUSY and latch dmem_addr_o=ALU_i, dmem_wdata_o=forward_b_data_i, dmem_we_o=MemW_i, plus pc_i, RegDst_i, RegWEn_i, WBSel_i.
REQ-014 BUSY: dmem_req_o=1 (registered); address, wdata, and we stay constant; stall_o=!dmem_ack_i.
REQ-015 BUSY with dmem_ack_i=1: the outputs load the latched instruction at that edge and the FSM returns to IDLE; stall_o=0 in that cycle, so upstream advances.
REQ-016 dmem_ack_i SHALL be ignored in IDLE.
REQ-017 IDLE without an access: stall_o=0; the outputs load the current inputs at the next edge (1-cycle latency).
REQ-018 Any edge where the outputs do not load an instruction SHALL load a bubble: RegWEn_o=0, RegDst_o=0, wb_data_o=0.
REQ-019 wb_data_o by WBSel: 0 gives ALU result, 1 gives dmem_rdata_i (loads) or 0 (stores), 2 gives pc+4 (modulo 2^32), 3 gives ALU result.
REQ-020 RegWEn_o SHALL be 0 whenever RegDst_o=0, and for every store.
REQ-021 Minimum load latency: access presented in cycle N, ack in cycle N+1, wb_data_o valid after the edge ending N+1.
REQ-022 Back-to-back accesses SHALL each pass through IDLE for one cycle before the next request.

Reset
REQ-023 While rst=1, the FSM SHALL be IDLE and all registered outputs 0 (dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o, wb_data_o, RegDst_o, RegWEn_o, bus_err_o); this takes effect immediately, without a clock edge.
REQ-024 Reset during BUSY SHALL abandon the access; dmem_req_o drops asynchronously and a late ack is ignored.

Configuration
REQ-025 Macro MEM_TIMEOUT_EN defined: a 4-bit counter clears on BUSY entry and increments each BUSY cycle without ack.
REQ-026 With MEM_TIMEOUT_EN, in the 16th BUSY cycle without ack: go to IDLE, drop dmem_req_o, load a bubble, pulse bus_err_o=1 for one cycle, and drive stall_o=0 in that cycle.
REQ-027 Without MEM_TIMEOUT_EN: no counter; BUSY waits indefinitely and bus_err_o is tied to 0.

Verification
REQ-028 ALU op, RegDst_i=5, WBSel_i=0, ALU_i=0x1234 -> next edge RegWEn_o=1, RegDst_o=5, wb_data_o=0x1234, stall_o never 1.
REQ-029 Load at addr 0x100, ack after 3 BUSY cycles with rdata 0xDEADBEEF -> stall_o=1 for 3 cycles; dmem_req_o=1 with addr 0x100 for 3 cycles; wb_data_o=0xDEADBEEF; bubbles during the stall.
REQ-030 Store of 0xA5A5A5A5 to 0x200 with ack on the first BUSY cycle -> dmem_we_o=1, wdata=0xA5A5A5A5; RegWEn_o=0 after completion.
REQ-031 JAL-type, pc_i=0xFFFFFFFC, WBSel_i=2 -> wb_data_o=0x00000000 (wrap-around).
REQ-032 rst=1 mid-BUSY followed by a late ack -> dmem_req_o=0 immediately, FSM in IDLE, no register write.
REQ-033 With MEM_TIMEOUT_EN, load never acked -> after 16 BUSY cycles bus_err_o pulses once, dmem_req_o=0, RegWEn_o=0, stall_o released.

Source files
------------

// File: rtl/mem_stage.sv
// mem_stage: MEM pipeline stage with IDLE/BUSY data-memory handshake; optional access timeout under MEM_TIMEOUT_EN
module mem_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_i,
    input  logic [31:0] ALU_i,
    input  logic [31:0] forward_b_data_i,
    input  logic [4:0]  RegDst_i,
    input  logic        MemR_i,
    input  logic        MemW_i,
    input  logic        RegWEn_i,
    input  logic [1:0]  WBSel_i,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic [31:0] dmem_addr_o,
    output logic [31:0] dmem_wdata_o,
    input  logic        dmem_ack_i,
    input  logic [31:0] dmem_rdata_i,
    output logic        stall_o,
    output logic [31:0] wb_data_o,
    output logic [4:0]  RegDst_o,
    output logic        RegWEn_o,
    output logic        bus_err_o
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    logic [0:0]  state_q, state_d;
    logic        req_q, we_q, rwen_q, lrwen_q;
    logic [31:0] addr_q, wdata_q, pc_q, wb_q;
    logic [4:0]  rd_q, lrd_q;
    logic [1:0]  lwbsel_q;
    logic        busy, access, ack, tmo, load_en, rwen_d;
    logic [31:0] sel_pc, sel_alu, mem_val, wb_d;
    logic [4:0]  sel_rd, rd_d;
    logic [1:0]  sel_wbsel;

`ifdef MEM_TIMEOUT_EN
    logic [3:0] cnt_q;
    logic       err_q;
    // Timeout counter: zero while idle, counts BUSY cycles without ack; error pulse follows the 16th
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= 4'd0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= !busy ? 4'd0 : (!dmem_ack_i ? cnt_q + 4'd1 : cnt_q);
            err_q <= tmo;
        end
    end
    assign tmo       = busy && !dmem_ack_i && cnt_q == 4'hF;
    assign bus_err_o = err_q;
`else
    assign tmo       = 1'b0;
    assign bus_err_o = 1'b0;
`endif

    // Next state and MEM/WB result: IDLE forwards live inputs, BUSY completes the latched access
    always_comb begin
        busy      = state_q == BUSY;
        access    = MemR_i | MemW_i;
        ack       = busy && dmem_ack_i;
        load_en   = busy ? ack : !access;
        state_d   = busy ? ((ack || tmo) ? IDLE : BUSY) : (access ? BUSY : IDLE);
        sel_pc    = busy ? pc_q : pc_i;
        sel_alu   = busy ? addr_q : ALU_i;
        sel_rd    = busy ? lrd_q : RegDst_i;
        sel_wbsel = busy ? lwbsel_q : WBSel_i;
        mem_val   = (busy && !we_q) ? dmem_rdata_i : 32'd0;
        wb_d      = !load_en ? 32'd0 : sel_wbsel == 2'd2 ? sel_pc + 32'd4 : sel_wbsel == 2'd1 ? mem_val : sel_alu;
        rd_d      = load_en ? sel_rd : 5'd0;
        rwen_d    = load_en && (busy ? lrwen_q : RegWEn_i) && sel_rd != 5'd0 && !(busy && we_q);
    end

    // FSM, request latch and MEM/WB output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= 32'd0;
            wdata_q  <= 32'd0;
            pc_q     <= 32'd0;
            lrd_q    <= 5'd0;
            lrwen_q  <= 1'b0;
            lwbsel_q <= 2'd0;
            wb_q     <= 32'd0;
            rd_q     <= 5'd0;
            rwen_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= state_d == BUSY;
            if (!busy && access) begin
                we_q     <= MemW_i;
                addr_q   <= ALU_i;
                wdata_q  <= forward_b_data_i;
                pc_q     <= pc_i;
                lrd_q    <= RegDst_i;
                lrwen_q  <= RegWEn_i;
                lwbsel_q <= WBSel_i;
            end
            wb_q   <= wb_d;
            rd_q   <= rd_d;
            rwen_q <= rwen_d;
        end
    end

    assign stall_o      = busy ? (!dmem_ack_i && !tmo) : access;
    assign dmem_req_o   = req_q;
    assign dmem_we_o    = we_q;
    assign dmem_addr_o  = addr_q;
    assign dmem_wdata_o = wdata_q;
    assign wb_data_o    = wb_q;
    assign RegDst_o     = rd_q;
    assign RegWEn_o     = rwen_q;
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: vector table plus scoreboarded memory sequences for mem_stage
module tb_mem_stage;
    logic        clk, rst;
    logic [31:0] pc_i, ALU_i, forward_b_data_i, dmem_rdata_i;
    logic [4:0]  RegDst_i;
    logic        MemR_i, MemW_i, RegWEn_i, dmem_ack_i;
    logic [1:0]  WBSel_i;
    logic        dmem_req_o, dmem_we_o, stall_o, RegWEn_o, bus_err_o;
    logic [31:0] dmem_addr_o, dmem_wdata_o, wb_data_o;
    logic [4:0]  RegDst_o;

    mem_stage dut (
        .clk(clk), .rst(rst), .pc_i(pc_i), .ALU_i(ALU_i), .forward_b_data_i(forward_b_data_i),
        .RegDst_i(RegDst_i), .MemR_i(MemR_i), .MemW_i(MemW_i), .RegWEn_i(RegWEn_i), .WBSel_i(WBSel_i),
        .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o), .dmem_wdata_o(dmem_wdata_o),
        .dmem_ack_i(dmem_ack_i), .dmem_rdata_i(dmem_rdata_i), .stall_o(stall_o), .wb_data_o(wb_data_o),
        .RegDst_o(RegDst_o), .RegWEn_o(RegWEn_o), .bus_err_o(bus_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc, alu;
        logic [4:0]  rd;
        logic        rwen;
        logic [1:0]  wbsel;
        logic [31:0] e_wb;
        logic [4:0]  e_rd;
        logic        e_rwen;
    } vec_t;
    typedef struct {
        logic [31:0] wb;
        logic [4:0]  rd;
        logic        rwen;
    } exp_t;

    vec_t vt[6];
    exp_t sb[$];
    int total = 0;
    int bad = 0;
    int stalls;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %h want %h", n, a, e);
        end
    endtask

    task automatic push(input logic [31:0] wb, input logic [4:0] rd, input logic rwen);
        exp_t e;
        e.wb = wb; e.rd = rd; e.rwen = rwen;
        sb.push_back(e);
    endtask

    task automatic pop_chk(input string n);
        exp_t e;
        if (sb.size() == 0) begin
            total++; bad++;
            $display("FAIL %s: scoreboard empty got %h want entry", n, wb_data_o);
        end else begin
            e = sb.pop_front();
            chk({n, "_wb"}, wb_data_o, e.wb);
            chk({n, "_rd"}, {27'd0, RegDst_o}, {27'd0, e.rd});
            chk({n, "_rwen"}, {31'd0, RegWEn_o}, {31'd0, e.rwen});
        end
    endtask

    task automatic bubble(input string n);
        chk({n, "_bub_wb"}, wb_data_o, 32'd0);
        chk({n, "_bub_rd"}, {27'd0, RegDst_o}, 32'd0);
        chk({n, "_bub_rwen"}, {31'd0, RegWEn_o}, 32'd0);
    endtask

    task automatic set(input logic [31:0] pc, alu, bd, input logic [4:0] rd,
                       input logic mr, mw, rwen, input logic [1:0] wbsel);
        pc_i = pc; ALU_i = alu; forward_b_data_i = bd; RegDst_i = rd;
        MemR_i = mr; MemW_i = mw; RegWEn_i = rwen; WBSel_i = wbsel;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        vt[0] = '{32'h0,        32'h1234, 5'd5,  1'b1, 2'd0, 32'h1234, 5'd5,  1'b1};
        vt[1] = '{32'hFFFFFFFC, 32'h55,   5'd1,  1'b1, 2'd2, 32'h0,    5'd1,  1'b1};
        vt[2] = '{32'h1000,     32'hCAFE, 5'd0,  1'b1, 2'd0, 32'hCAFE, 5'd0,  1'b0};
        vt[3] = '{32'h2000,     32'h77,   5'd9,  1'b1, 2'd3, 32'h77,   5'd9,  1'b1};
        vt[4] = '{32'h3000,     32'h88,   5'd10, 1'b0, 2'd2, 32'h3004, 5'd10, 1'b0};
        vt[5] = '{32'h40,       32'h99,   5'd31, 1'b1, 2'd2, 32'h44,   5'd31, 1'b1};
        rst = 1'b1; dmem_ack_i = 1'b0; dmem_rdata_i = 32'h13579BDF;
        set(0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        chk("rst_req", dmem_req_o, 0);
        chk("rst_we", dmem_we_o, 0);
        chk("rst_addr", dmem_addr_o, 0);
        chk("rst_wdata", dmem_wdata_o, 0);
        chk("rst_err", bus_err_o, 0);
        chk("rst_stall", stall_o, 0);
        bubble("rst");
        @(posedge clk); @(negedge clk) rst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            set(vt[i].pc, vt[i].alu, 32'hBAD0, vt[i].rd, 0, 0, vt[i].rwen, vt[i].wbsel);
            push(vt[i].e_wb, vt[i].e_rd, vt[i].e_rwen);
            #1 chk($sformatf("vec%0d_stall", i), stall_o, 0);
            @(posedge clk); #1;
            pop_chk($sformatf("vec%0d", i));
            chk($sformatf("vec%0d_req", i), dmem_req_o, 0);
        end

        @(negedge clk);
        set(32'h500, 32'h100, 32'h11, 5'd7, 1, 0, 1, 2'd1);
        dmem_ack_i = 1'b1; dmem_rdata_i = 32'hDEADBEEF;
        push(32'hDEADBEEF, 5'd7, 1'b1);
        stalls = 0;
        #1 stalls += int'(stall_o);
        chk("ld_idle_stall", stall_o, 1);
        @(posedge clk); #1;
        bubble("ld_entry");
        for (int k = 0; k < 3; k++) begin
            @(negedge clk) dmem_ack_i = (k == 2);
            #1 stalls += int'(stall_o);
            chk($sformatf("ld_req%0d", k), dmem_req_o, 1);
            chk($sformatf("ld_addr%0d", k), dmem_addr_o, 32'h100);
            chk($sformatf("ld_we%0d", k), dmem_we_o, 0);
            @(posedge clk); #1;
            if (k < 2) bubble($sformatf("ld_busy%0d", k));
            else pop_chk("ld_done");
        end
        chk("ld_stall_cycles", stalls, 3);
        chk("ld_req_drop", dmem_req_o, 0);
        @(negedge clk) set(0, 0, 0, 0, 0, 0, 0, 0); dmem_ack_i = 1'b0;

        @(negedge clk);
        set(32'h600, 32'h200, 32'hA5A5A5A5, 5'd3, 0, 1, 1, 2'd1);
        push(32'h0, 5'd3, 1'b0);
        #1 chk("st_idle_stall", stall_o, 1);
        @(posedge clk); #1;
        chk("st_we", dmem_we_o, 1);
        chk("st_wdata", dmem_wdata_o, 32'hA5A5A5A5);
        chk("st_addr", dmem_addr_o, 32'h200);
        chk("st_req", dmem_req_o, 1);
        @(negedge clk) dmem_ack_i = 1'b1;
        #1 chk("st_ack_stall", stall_o, 0);
        @(posedge clk); #1;
        pop_chk("st_done");
        chk("st_req_drop", dmem_req_o, 0);
        @(negedge clk) dmem_ack_i = 1'b0;
        push(32'h0, 5'd3, 1'b0);
        #1 chk("b2b_idle_req", dmem_req_o, 0);
        chk("b2b_idle_stall", stall_o, 1);
        @(posedge clk); #1 chk("b2b_req", dmem_req_o, 1);
        @(negedge clk) dmem_ack_i = 1'b1;
        @(posedge clk); #1 pop_chk("b2b_done");
        @(negedge clk) set(0, 0, 0, 0, 0, 0, 0, 0); dmem_ack_i = 1'b0;

        @(negedge clk) set(32'h700, 32'h300, 32'h0, 5'd8, 1, 0, 1, 2'd1);
        @(posedge clk); #1 chk("rb_req", dmem_req_o, 1);
        @(negedge clk) rst = 1'b1;
        #1 chk("rb_req_async", dmem_req_o, 0);
        chk("rb_addr_async", dmem_addr_o, 0);
        bubble("rb_async");
        @(posedge clk);
        @(negedge clk) rst = 1'b0; dmem_ack_i = 1'b1; set(0, 0, 0, 0, 0, 0, 0, 0);
        #1 chk("rb_late_stall", stall_o, 0);
        @(posedge clk); #1;
        chk("rb_late_req", dmem_req_o, 0);
        bubble("rb_late");
        @(negedge clk) dmem_ack_i = 1'b0;

`ifdef MEM_TIMEOUT_EN
        @(negedge clk) set(32'h800, 32'h400, 32'h0, 5'd9, 1, 0, 1, 2'd1);
        @(posedge clk); #1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            #1 chk($sformatf("to_stall%0d", i), stall_o, (i != 15));
            @(posedge clk); #1;
            if (i < 15) begin
                chk($sformatf("to_req%0d", i), dmem_req_o, 1);
                chk($sformatf("to_err%0d", i), bus_err_o, 0);
            end else begin
                chk("to_err_pulse", bus_err_o, 1);
                chk("to_req_drop", dmem_req_o, 0);
                bubble("to_end");
            end
        end
        @(negedge clk) set(0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #1 chk("to_err_clear", bus_err_o, 0);
`else
        @(negedge clk) set(32'h800, 32'h400, 32'h0, 5'd9, 1, 0, 1, 2'd1);
        push(32'h2468ACE0, 5'd9, 1'b1);
        @(posedge clk); #1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #1 chk($sformatf("wait_stall%0d", i), stall_o, 1);
            chk($sformatf("wait_err%0d", i), bus_err_o, 0);
            @(posedge clk); #1 chk($sformatf("wait_req%0d", i), dmem_req_o, 1);
        end
        @(negedge clk) dmem_ack_i = 1'b1; dmem_rdata_i = 32'h2468ACE0;
        @(posedge clk); #1 pop_chk("wait_done");
        @(negedge clk) dmem_ack_i = 1'b0; set(0, 0, 0, 0, 0, 0, 0, 0);
`endif
        chk("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
